// File: rtl/key_input_conditioner.sv
// ---------------------------------------------------------------------------
// key_input_conditioner
//
// Front end between the raw DE-series KEY[3:0] push buttons and the game
// control FSM. Each key is synchronised and debounced. The highest-priority
// held key (up > down > left > right) becomes a sticky move request. A
// request stays asserted until control acknowledges it, so no debounced
// press is lost while control is busy drawing.
//
// Configuration macro:
//   KEY_AUTOREPEAT_EN  defined   -> a held key re-requests after REPEAT_DELAY
//                                   cycles, then every REPEAT_RATE cycles.
//                      undefined -> one move per press; REPEAT_* unused.
//
// Ports:
//   clock    in   1  system clock (CLOCK_50)
//   reset    in   1  asynchronous, active-high reset
//   key_n    in   4  raw keys, active-low, asynchronous
//                    [3]=up [2]=down [1]=left [0]=right
//   req_ack  in   1  control is executing a move
//   c_up     out  1  registered move-up request
//   c_down   out  1  registered move-down request
//   c_left   out  1  registered move-left request
//   c_right  out  1  registered move-right request
//   held     out  4  debounced pressed level per key, active-high,
//                    same bit order as key_n
// ---------------------------------------------------------------------------
module key_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       req_ack,
    output logic       c_up,
    output logic       c_down,
    output logic       c_left,
    output logic       c_right,
    output logic [3:0] held
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Largest count any counter must reach; elaboration stops if CNT_W is too narrow.
    localparam longint MAX_CNT =
        (DEBOUNCE_CYCLES > REPEAT_DELAY)
            ? ((DEBOUNCE_CYCLES > REPEAT_RATE) ? longint'(DEBOUNCE_CYCLES) : longint'(REPEAT_RATE))
            : ((REPEAT_DELAY    > REPEAT_RATE) ? longint'(REPEAT_DELAY)    : longint'(REPEAT_RATE));

    if (MAX_CNT >= (longint'(1) << CNT_W)) begin : g_cnt_w_too_small
        $error("key_input_conditioner: CNT_W too small for the configured counts");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser: two flops per key, reset to the released (high) level
    // so that no phantom press appears when reset is released.
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_synced;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_synced = ~r_sync2;

    // ------------------------------------------------------------------
    // Debounce: a key's counter runs only while its synced level disagrees
    // with the debounced level. The level flips once the disagreement has
    // persisted for DEBOUNCE_CYCLES consecutive samples.
    // ------------------------------------------------------------------
    logic [3:0]       r_db;
    logic [CNT_W-1:0] r_db_cnt [4];

    // NOTE: the counter array is only four registers, not a RAM, so it is
    // reset together with the levels to guarantee a clean start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_db <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_synced[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= w_synced[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign held = r_db;

    // ------------------------------------------------------------------
    // Priority select: one-hot of the highest-priority held key.
    // ------------------------------------------------------------------
    logic [3:0] w_dir;

    // NOTE: every always_comb output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_dir = 4'b0000;
        if      (r_db[3]) w_dir = 4'b1000;
        else if (r_db[2]) w_dir = 4'b0100;
        else if (r_db[1]) w_dir = 4'b0010;
        else if (r_db[0]) w_dir = 4'b0001;
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_dir;        // key the current request belongs to
    logic [3:0] w_dir_next;
    logic [3:0] r_req;        // registered c_* outputs, one-hot or zero
    logic [3:0] w_req_next;

`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_next;
    logic [CNT_W-1:0] r_reload;   // timer value to use once the pending request is acked
    logic [CNT_W-1:0] w_reload_next;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_dir    <= '0;
            r_req    <= '0;
`ifdef KEY_AUTOREPEAT_EN
            r_timer  <= '0;
            r_reload <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_dir    <= w_dir_next;
            r_req    <= w_req_next;
`ifdef KEY_AUTOREPEAT_EN
            r_timer  <= w_timer_next;
            r_reload <= w_reload_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_dir_next    = r_dir;
        w_req_next    = r_req;
`ifdef KEY_AUTOREPEAT_EN
        w_timer_next  = r_timer;
        w_reload_next = r_reload;
`endif
        case (r_state)
            S_IDLE: begin
                w_req_next = '0;
                if (w_dir != 4'b0000) begin
                    w_dir_next    = w_dir;
                    w_req_next    = w_dir;
`ifdef KEY_AUTOREPEAT_EN
                    w_reload_next = CNT_W'(REPEAT_DELAY);
`endif
                    w_state_next  = S_PEND;
                end
            end

            // Request is held even if the key is released meanwhile.
            S_PEND: begin
                if (req_ack) begin
                    w_req_next   = '0;
`ifdef KEY_AUTOREPEAT_EN
                    w_timer_next = r_reload;
`endif
                    w_state_next = S_HOLD;
                end
            end

            // Release of the latched key wins over an expiring timer.
            S_HOLD: begin
                if ((r_dir & r_db) == 4'b0000) begin
                    w_state_next = S_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                end else if (r_timer == '0) begin
                    // The latched key is still held, so w_dir is non-zero here.
                    w_dir_next    = w_dir;
                    w_req_next    = w_dir;
                    w_reload_next = CNT_W'(REPEAT_RATE);
                    w_state_next  = S_PEND;
                end else begin
                    w_timer_next = r_timer - 1'b1;
`endif
                end
            end

            default: begin
                w_req_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign c_up    = r_req[3];
    assign c_down  = r_req[2];
    assign c_left  = r_req[1];
    assign c_right = r_req[0];

endmodule

// File: tb/tb_key_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_input_conditioner
//
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=8. Inputs change 1 time unit after a rising
// edge ("cycle 0"); outputs are sampled 1 time unit after the edge.
// Request vector order is {c_up, c_down, c_left, c_right}.
// ---------------------------------------------------------------------------
module tb_key_input_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] key_n;
    logic       req_ack;
    logic       c_up;
    logic       c_down;
    logic       c_left;
    logic       c_right;
    logic [3:0] held;

    logic [3:0] w_c;
    assign w_c = {c_up, c_down, c_left, c_right};

    int n_checks = 0;
    int n_errors = 0;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .CNT_W           (25)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .key_n   (key_n),
        .req_ack (req_ack),
        .c_up    (c_up),
        .c_down  (c_down),
        .c_left  (c_left),
        .c_right (c_right),
        .held    (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ack_pulse();
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [3:0] seen;
        int         n;
        int         hits;

        reset   = 1'b1;
        key_n   = 4'hF;
        req_ack = 1'b0;
        tick();
        tick();
        check("reset_held", held, 4'h0);
        check("reset_req", w_c, 4'h0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_req", w_c, 4'h0);

        // 1. Press up: held[3] after 6 edges, c_up after 7, sticky until ack.
        key_n = 4'b0111;
        repeat (6) tick();
        check("t1_req_before", w_c, 4'h0);
        check("t1_held", held, 4'b1000);
        tick();
        check("t1_c_up", w_c, 4'b1000);
        seen = 4'h0;
        repeat (5) begin
            tick();
            seen = seen | ~w_c;
        end
        check("t1_c_up_sticky", seen, 4'b0111);
        ack_pulse();
        check("t1_after_ack", w_c, 4'h0);
        key_n = 4'hF;
        repeat (12) tick();
        check("t1_release_held", held, 4'h0);
        check("t1_release_req", w_c, 4'h0);

        // 2. Three-cycle glitch on left: nothing changes.
        seen  = 4'h0;
        key_n = 4'b1101;
        repeat (3) begin
            tick();
            seen = seen | held | w_c;
        end
        key_n = 4'hF;
        repeat (12) begin
            tick();
            seen = seen | held | w_c;
        end
        check("t2_glitch", seen, 4'h0);

        // 3. Up and right together: only up; right follows after up released.
        key_n = 4'b0110;
        repeat (7) tick();
        check("t3_only_up", w_c, 4'b1000);
        check("t3_held", held, 4'b1001);
        ack_pulse();
        check("t3_ack_clear", w_c, 4'h0);
        key_n = 4'b1110;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (held[3] == 1'b0) begin
                n = i;
                break;
            end
        end
        check("t3_up_release_latency", n, 6);
        tick();
        check("t3_idle_no_req", w_c, 4'h0);
        tick();
        check("t3_c_right", w_c, 4'b0001);
        ack_pulse();
        key_n = 4'hF;
        repeat (12) tick();
        check("t3_final", w_c, 4'h0);

        // 4. Down pressed, never acked for 100 cycles, released at 50.
        key_n = 4'b1011;
        hits  = 0;
        seen  = 4'h0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (cyc < 7) seen = seen | w_c;
            else if (w_c == 4'b0100) hits++;
            if (cyc == 50) key_n = 4'hF;
        end
        check("t4_no_early_req", seen, 4'h0);
        check("t4_c_down_cycles", hits, 94);
        ack_pulse();
        check("t4_ack_clear", w_c, 4'h0);
        seen = 4'h0;
        repeat (20) begin
            tick();
            seen = seen | w_c;
        end
        check("t4_no_further_req", seen, 4'h0);
        check("t4_held", held, 4'h0);

        // 5. Hold right, ack each request promptly.
        key_n = 4'b1110;
        repeat (7) tick();
        check("t5_first_req", w_c, 4'b0001);
        ack_pulse();
        check("t5_ack_clear", w_c, 4'h0);
`ifdef KEY_AUTOREPEAT_EN
        repeat (20) tick();
        check("t5_delay_not_yet", w_c, 4'h0);
        tick();
        check("t5_first_repeat", w_c, 4'b0001);
        ack_pulse();
        check("t5_repeat_ack_clear", w_c, 4'h0);
        repeat (8) tick();
        check("t5_rate_not_yet", w_c, 4'h0);
        tick();
        check("t5_second_repeat", w_c, 4'b0001);
        ack_pulse();
`else
        seen = 4'h0;
        repeat (60) begin
            tick();
            seen = seen | w_c;
        end
        check("t5_no_repeat", seen, 4'h0);
`endif
        key_n = 4'hF;
        repeat (12) tick();
        check("t5_final", w_c, 4'h0);

        // 6. Async reset while c_left is pending, key kept pressed.
        key_n = 4'b1101;
        repeat (7) tick();
        check("t6_c_left", w_c, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("t6_reset_req", w_c, 4'h0);
        check("t6_reset_held", held, 4'h0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("t6_no_req_yet", w_c, 4'h0);
        check("t6_held_again", held, 4'b0010);
        tick();
        check("t6_req_after_debounce", w_c, 4'b0010);
        ack_pulse();
        key_n = 4'hF;
        repeat (12) tick();
        check("t6_final", w_c, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
